// File: rtl/cpu_pkg.sv
// Shared definitions for the hardwired control unit: state encoding, opcodes,
// ALU operation codes and small opcode-decode helpers.
package cpu_pkg;

  localparam int OP_W = 5;
  typedef logic [OP_W-1:0] opcode_t;
  typedef logic [3:0] alu_t;

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  localparam opcode_t OP_LD   = 5'd0,  OP_LDI  = 5'd1,  OP_ST   = 5'd2;
  localparam opcode_t OP_ADD  = 5'd3,  OP_SUB  = 5'd4,  OP_SHR  = 5'd5;
  localparam opcode_t OP_SHL  = 5'd6,  OP_ROR  = 5'd7,  OP_ROL  = 5'd8;
  localparam opcode_t OP_AND  = 5'd9,  OP_OR   = 5'd10, OP_ADDI = 5'd11;
  localparam opcode_t OP_ANDI = 5'd12, OP_ORI  = 5'd13, OP_MUL  = 5'd14;
  localparam opcode_t OP_DIV  = 5'd15, OP_NEG  = 5'd16, OP_NOT  = 5'd17;
  localparam opcode_t OP_BR   = 5'd18, OP_JR   = 5'd19, OP_JAL  = 5'd20;
  localparam opcode_t OP_IN   = 5'd21, OP_OUT  = 5'd22, OP_MFHI = 5'd23;
  localparam opcode_t OP_MFLO = 5'd24, OP_NOP  = 5'd25, OP_HALT = 5'd26;

  localparam alu_t ALU_AND = 4'd0, ALU_OR  = 4'd1, ALU_ADD = 4'd2,  ALU_SUB = 4'd3;
  localparam alu_t ALU_MUL = 4'd4, ALU_DIV = 4'd5, ALU_SHR = 4'd6,  ALU_SHL = 4'd7;
  localparam alu_t ALU_ROR = 4'd8, ALU_ROL = 4'd9, ALU_NEG = 4'd10, ALU_NOT = 4'd11;

  // Field order matches the port concatenation in control_unit.
  typedef struct packed {
    logic pc_out, zlow_out, zhigh_out, mdr_out, hi_out, lo_out, inport_out, c_out, ba_out, r_out;
    logic pc_in, mar_in, mdr_in, ir_in, y_in, zlow_in, zhigh_in, hi_in, lo_in, con_in, outport_in, r_in, inc_pc;
    logic gra, grb, grc;
    logic read, write;
    logic [1:0] mdr_read;
    alu_t control;
  } ctrl_t;

  function automatic logic is_rtype(opcode_t op);
    return (op >= OP_ADD) && (op <= OP_OR);
  endfunction

  function automatic logic is_imm(opcode_t op);
    return (op >= OP_ADDI) && (op <= OP_ORI);
  endfunction

  function automatic alu_t alu_code(opcode_t op);
    case (op)
      OP_SUB:           return ALU_SUB;
      OP_SHR:           return ALU_SHR;
      OP_SHL:           return ALU_SHL;
      OP_ROR:           return ALU_ROR;
      OP_ROL:           return ALU_ROL;
      OP_AND, OP_ANDI:  return ALU_AND;
      OP_OR, OP_ORI:    return ALU_OR;
      OP_MUL:           return ALU_MUL;
      OP_DIV:           return ALU_DIV;
      OP_NEG:           return ALU_NEG;
      OP_NOT:           return ALU_NOT;
      default:          return ALU_ADD;
    endcase
  endfunction

  // Final T-state of each instruction; the boundary back to T0 follows it.
  function automatic state_t last_step(opcode_t op);
    if (is_rtype(op) || is_imm(op) || op == OP_LDI) return S_T5;
    case (op)
      OP_LD, OP_ST:                        return S_T7;
      OP_MUL, OP_DIV, OP_BR:               return S_T6;
      OP_NEG, OP_NOT, OP_JAL:              return S_T4;
      OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO: return S_T3;
      default:                             return S_T2;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready cycles in a memory wait state and flags the
// cycle in which the wait would reach MEM_TIMEOUT.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic waiting,
  input  logic mem_ready,
  output logic first,
  output logic expire
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

  logic [CW-1:0] count_reg;

  assign first  = (count_reg == '0);
  // A ready memory in the final cycle still completes the access.
  assign expire = waiting && !mem_ready && (count_reg == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      count_reg <= '0;
    else if (waiting && !mem_ready && !expire)
      count_reg <= count_reg + CW'(1);
    else
      count_reg <= '0;
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore control unit sequencing the single-bus datapath through
// fetch, decode and execute, with bounded memory waits and halt/stop control.
module control_unit
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int OPW         = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR,
  input  logic        Branch,
  input  logic        mem_ready,
  input  logic        stop,
  output logic        PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout, BAout, Rout,
  output logic        PCin, MARin, MDRin, IRin, Yin, Zlowin, Zhighin, HIin, LOin, CONin, OutPortin, Rin, IncPc,
  output logic        GRA, GRB, GRC,
  output logic        read, write,
  output logic [1:0]  mdr_read,
  output logic [3:0]  control,
  output logic        run,
  output logic        mem_fault
);

  state_t         state_reg, state_next, at_boundary;
  opcode_t        op;
  logic [OPW-1:0] op_field;
  logic           unused_ir;
  logic           waiting, first, expire;
  ctrl_t          ctrl;

  assign op_field  = IR[31 -: OPW];
  assign op        = opcode_t'(op_field);
  assign unused_ir = ^IR[31-OPW:0];

  assign waiting = (state_reg == S_T1) ||
                   (state_reg == S_T6 && op == OP_LD) ||
                   (state_reg == S_T7 && op == OP_ST);
  assign at_boundary = stop ? S_HALT : S_T0;

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .waiting   (waiting),
    .mem_ready (mem_ready),
    .first     (first),
    .expire    (expire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_RST;
      mem_fault <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (expire) mem_fault <= 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_RST:  state_next = at_boundary;
      S_T0:   state_next = S_T1;
      S_HALT: state_next = S_HALT;
      S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7: begin
        if (waiting && !mem_ready)
          state_next = expire ? S_HALT : state_reg;
        else if (state_reg == S_T2 && op == OP_HALT)
          state_next = S_HALT;
        else if (state_reg == last_step(op))
          state_next = at_boundary;
        else
          state_next = state_t'(state_reg + 4'd1);
      end
      default: state_next = S_RST;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (state_reg)
      S_T0: begin ctrl.pc_out = 1'b1; ctrl.mar_in = 1'b1; ctrl.inc_pc = 1'b1; ctrl.zlow_in = 1'b1; end
      S_T1: begin
        ctrl.zlow_out = 1'b1; ctrl.pc_in = first; ctrl.read = 1'b1;
        ctrl.mdr_read = 2'b01; ctrl.mdr_in = 1'b1;
      end
      S_T2: begin ctrl.mdr_out = 1'b1; ctrl.ir_in = 1'b1; end
      S_T3: begin
        if (is_rtype(op) || is_imm(op)) begin
          ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1;
        end else begin
          case (op)
            OP_LD, OP_LDI, OP_ST: begin ctrl.grb = 1'b1; ctrl.ba_out = 1'b1; ctrl.y_in = 1'b1; end
            OP_NEG, OP_NOT: begin
              ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.control = alu_code(op); ctrl.zlow_in = 1'b1;
            end
            OP_MUL, OP_DIV: begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1; end
            OP_BR:   begin ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.con_in = 1'b1; end
            OP_JR:   begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.pc_in = 1'b1; end
            OP_JAL:  begin ctrl.pc_out = 1'b1; ctrl.grb = 1'b1; ctrl.r_in = 1'b1; end
            OP_IN:   begin ctrl.inport_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
            OP_OUT:  begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.outport_in = 1'b1; end
            OP_MFHI: begin ctrl.hi_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
            OP_MFLO: begin ctrl.lo_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
            default: ;
          endcase
        end
      end
      S_T4: begin
        if (is_rtype(op)) begin
          ctrl.grc = 1'b1; ctrl.r_out = 1'b1; ctrl.control = alu_code(op); ctrl.zlow_in = 1'b1;
        end else if (is_imm(op)) begin
          ctrl.c_out = 1'b1; ctrl.control = alu_code(op); ctrl.zlow_in = 1'b1;
        end else begin
          case (op)
            OP_LD, OP_LDI, OP_ST: begin ctrl.c_out = 1'b1; ctrl.control = ALU_ADD; ctrl.zlow_in = 1'b1; end
            OP_NEG, OP_NOT: begin ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
            OP_MUL, OP_DIV: begin
              ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.control = alu_code(op);
              ctrl.zlow_in = 1'b1; ctrl.zhigh_in = 1'b1;
            end
            OP_BR:  begin ctrl.pc_out = 1'b1; ctrl.y_in = 1'b1; end
            OP_JAL: begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.pc_in = 1'b1; end
            default: ;
          endcase
        end
      end
      S_T5: begin
        if (is_rtype(op) || is_imm(op) || op == OP_LDI) begin
          ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
        end else begin
          case (op)
            OP_LD, OP_ST:   begin ctrl.zlow_out = 1'b1; ctrl.mar_in = 1'b1; end
            OP_MUL, OP_DIV: begin ctrl.zlow_out = 1'b1; ctrl.lo_in = 1'b1; end
            OP_BR: begin ctrl.c_out = 1'b1; ctrl.control = ALU_ADD; ctrl.zlow_in = 1'b1; end
            default: ;
          endcase
        end
      end
      S_T6: begin
        case (op)
          OP_LD: begin ctrl.read = 1'b1; ctrl.mdr_read = 2'b01; ctrl.mdr_in = 1'b1; end
          OP_ST: begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.mdr_read = 2'b00; ctrl.mdr_in = 1'b1; end
          OP_MUL, OP_DIV: begin ctrl.zhigh_out = 1'b1; ctrl.hi_in = 1'b1; end
          OP_BR: begin ctrl.zlow_out = Branch; ctrl.pc_in = Branch; end
          default: ;
        endcase
      end
      S_T7: begin
        case (op)
          OP_LD: begin ctrl.mdr_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
          OP_ST: ctrl.write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign {PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout, BAout, Rout,
          PCin, MARin, MDRin, IRin, Yin, Zlowin, Zhighin, HIin, LOin, CONin, OutPortin, Rin, IncPc,
          GRA, GRB, GRC, read, write, mdr_read, control} = ctrl;
  assign run = (state_reg != S_RST) && (state_reg != S_HALT);

endmodule

// File: tb/tb_control_unit.sv
// Directed, table-driven bench for control_unit: one cycle per vector, outputs
// compared half a clock after each rising edge against hand-computed strobes.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] IR = 32'h0;
  logic        Branch = 1'b0, mem_ready = 1'b1, stop = 1'b0;
  logic PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout, BAout, Rout;
  logic PCin, MARin, MDRin, IRin, Yin, Zlowin, Zhighin, HIin, LOin, CONin, OutPortin, Rin, IncPc;
  logic GRA, GRB, GRC, read, write, run, mem_fault;
  logic [1:0] mdr_read;
  logic [3:0] control;

  control_unit #(.MEM_TIMEOUT(15), .OPW(5)) dut (
    .clk(clk), .reset(reset), .IR(IR), .Branch(Branch), .mem_ready(mem_ready), .stop(stop),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout), .HIout(HIout),
    .LOout(LOout), .InPortout(InPortout), .Cout(Cout), .BAout(BAout), .Rout(Rout),
    .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zlowin(Zlowin),
    .Zhighin(Zhighin), .HIin(HIin), .LOin(LOin), .CONin(CONin), .OutPortin(OutPortin),
    .Rin(Rin), .IncPc(IncPc), .GRA(GRA), .GRB(GRB), .GRC(GRC), .read(read), .write(write),
    .mdr_read(mdr_read), .control(control), .run(run), .mem_fault(mem_fault)
  );

  always #5 clk = ~clk;

  logic [29:0] obs;
  assign obs = {mem_fault, run, write, read, GRC, GRB, GRA, IncPc, Rin, OutPortin, CONin, LOin,
                HIin, Zhighin, Zlowin, Yin, IRin, MDRin, MARin, PCin, Rout, BAout, Cout,
                InPortout, LOout, HIout, MDRout, Zhighout, Zlowout, PCout};

  localparam logic [29:0] M_PCOUT = 30'd1 << 0,  M_ZLOWOUT = 30'd1 << 1,  M_ZHIGHOUT = 30'd1 << 2;
  localparam logic [29:0] M_MDROUT = 30'd1 << 3, M_HIOUT = 30'd1 << 4,    M_LOOUT = 30'd1 << 5;
  localparam logic [29:0] M_INPORT = 30'd1 << 6, M_COUT = 30'd1 << 7,     M_BAOUT = 30'd1 << 8;
  localparam logic [29:0] M_ROUT = 30'd1 << 9,   M_PCIN = 30'd1 << 10,    M_MARIN = 30'd1 << 11;
  localparam logic [29:0] M_MDRIN = 30'd1 << 12, M_IRIN = 30'd1 << 13,    M_YIN = 30'd1 << 14;
  localparam logic [29:0] M_ZLOWIN = 30'd1 << 15, M_ZHIGHIN = 30'd1 << 16, M_HIIN = 30'd1 << 17;
  localparam logic [29:0] M_LOIN = 30'd1 << 18,  M_CONIN = 30'd1 << 19,   M_OUTPORT = 30'd1 << 20;
  localparam logic [29:0] M_RIN = 30'd1 << 21,   M_INCPC = 30'd1 << 22,   M_GRA = 30'd1 << 23;
  localparam logic [29:0] M_GRB = 30'd1 << 24,   M_GRC = 30'd1 << 25,     M_READ = 30'd1 << 26;
  localparam logic [29:0] M_WRITE = 30'd1 << 27, M_RUN = 30'd1 << 28,     M_FAULT = 30'd1 << 29;

  localparam logic [29:0] T0V = M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_ZLOWIN;
  localparam logic [29:0] T1V = M_RUN | M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN;
  localparam logic [29:0] T1W = M_RUN | M_ZLOWOUT | M_READ | M_MDRIN;
  localparam logic [29:0] T2V = M_RUN | M_MDROUT | M_IRIN;

  localparam logic [31:0] I_LDI = 32'h08800012, I_ADD = 32'h18912000, I_SUB = 32'h20000000;
  localparam logic [31:0] I_ANDI = 32'h60000000, I_NEG = 32'h80000000, I_BR = 32'h90000000;
  localparam logic [31:0] I_MUL = 32'h70000000, I_JAL = 32'hA0000000, I_ST = 32'h10000000;
  localparam logic [31:0] I_NOP = 32'hC8000000, I_LD = 32'h00000000, I_HLT = 32'hD0000000;

  typedef struct {
    string       name;
    logic        rst;
    logic [31:0] ir;
    logic        br, rdy, stp;
    logic [29:0] bits;
    logic [3:0]  ctl;
    logic [1:0]  mdr;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic add(input string name, input logic [31:0] ir, input logic [29:0] bits,
                     input logic [3:0] ctl = 4'd0, input logic [1:0] mdr = 2'd0,
                     input logic br = 1'b0, input logic rdy = 1'b1, input logic stp = 1'b0,
                     input logic rst = 1'b1);
    vec_t v;
    v.name = name; v.rst = rst; v.ir = ir; v.br = br; v.rdy = rdy; v.stp = stp;
    v.bits = bits; v.ctl = ctl; v.mdr = mdr;
    tbl.push_back(v);
  endtask

  task automatic add_fetch(input string p, input logic [31:0] ir, input logic br = 1'b0);
    add({p, ".T0"}, ir, T0V, 4'd0, 2'd0, br);
    add({p, ".T1"}, ir, T1V, 4'd0, 2'd1, br);
    add({p, ".T2"}, ir, T2V, 4'd0, 2'd0, br);
  endtask

  task automatic step(input string name, input logic rst, input logic [31:0] ir, input logic br,
                      input logic rdy, input logic stp, input logic [29:0] eb,
                      input logic [3:0] ec, input logic [1:0] em);
    @(negedge clk);
    reset = rst; IR = ir; Branch = br; mem_ready = rdy; stop = stp;
    #1;
    n_checks++;
    if (obs === eb && control === ec && mdr_read === em) begin
      n_pass++;
      $display("ok   %s bits=%h control=%0d mdr_read=%0d", name, obs, control, mdr_read);
    end else begin
      $display("FAIL %s: bits=%h required %h, control=%0d required %0d, mdr_read=%0d required %0d",
               name, obs, eb, control, ec, mdr_read, em);
    end
  endtask

  initial begin
    // Reset and fetch with a slow memory, then ldi.
    add("rst.hold", I_ADD, 30'd0, 4'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    add("rst.RST",  I_ADD, 30'd0);
    add("ldi.T0",  I_LDI, T0V);
    add("ldi.T1a", I_LDI, T1V, 4'd0, 2'd1, 1'b0, 1'b0);
    add("ldi.T1b", I_LDI, T1W, 4'd0, 2'd1, 1'b0, 1'b0);
    add("ldi.T1c", I_LDI, T1W, 4'd0, 2'd1, 1'b0, 1'b0);
    add("ldi.T1d", I_LDI, T1W, 4'd0, 2'd1, 1'b0, 1'b1);
    add("ldi.T2",  I_LDI, T2V);
    add("ldi.T3",  I_LDI, M_RUN | M_GRB | M_BAOUT | M_YIN);
    add("ldi.T4",  I_LDI, M_RUN | M_COUT | M_ZLOWIN, 4'd2);
    add("ldi.T5",  I_LDI, M_RUN | M_ZLOWOUT | M_GRA | M_RIN);
    add_fetch("add", I_ADD);
    add("add.T3", I_ADD, M_RUN | M_GRB | M_ROUT | M_YIN);
    add("add.T4", I_ADD, M_RUN | M_GRC | M_ROUT | M_ZLOWIN, 4'd2);
    add("add.T5", I_ADD, M_RUN | M_ZLOWOUT | M_GRA | M_RIN);
    add_fetch("sub", I_SUB);
    add("sub.T3", I_SUB, M_RUN | M_GRB | M_ROUT | M_YIN);
    add("sub.T4", I_SUB, M_RUN | M_GRC | M_ROUT | M_ZLOWIN, 4'd3);
    add("sub.T5", I_SUB, M_RUN | M_ZLOWOUT | M_GRA | M_RIN);
    add_fetch("andi", I_ANDI);
    add("andi.T3", I_ANDI, M_RUN | M_GRB | M_ROUT | M_YIN);
    add("andi.T4", I_ANDI, M_RUN | M_COUT | M_ZLOWIN, 4'd0);
    add("andi.T5", I_ANDI, M_RUN | M_ZLOWOUT | M_GRA | M_RIN);
    add_fetch("neg", I_NEG);
    add("neg.T3", I_NEG, M_RUN | M_GRB | M_ROUT | M_ZLOWIN, 4'd10);
    add("neg.T4", I_NEG, M_RUN | M_ZLOWOUT | M_GRA | M_RIN);
    for (int b = 0; b < 2; b++) begin
      add_fetch("br", I_BR, b[0]);
      add("br.T3", I_BR, M_RUN | M_GRB | M_ROUT | M_CONIN, 4'd0, 2'd0, b[0]);
      add("br.T4", I_BR, M_RUN | M_PCOUT | M_YIN, 4'd0, 2'd0, b[0]);
      add("br.T5", I_BR, M_RUN | M_COUT | M_ZLOWIN, 4'd2, 2'd0, b[0]);
      add("br.T6", I_BR, (b == 1) ? (M_RUN | M_ZLOWOUT | M_PCIN) : M_RUN, 4'd0, 2'd0, b[0]);
    end
    add_fetch("mul", I_MUL);
    add("mul.T3", I_MUL, M_RUN | M_GRA | M_ROUT | M_YIN);
    add("mul.T4", I_MUL, M_RUN | M_GRB | M_ROUT | M_ZLOWIN | M_ZHIGHIN, 4'd4);
    add("mul.T5", I_MUL, M_RUN | M_ZLOWOUT | M_LOIN);
    add("mul.T6", I_MUL, M_RUN | M_ZHIGHOUT | M_HIIN);
    add_fetch("jal", I_JAL);
    add("jal.T3", I_JAL, M_RUN | M_PCOUT | M_GRB | M_RIN);
    add("jal.T4", I_JAL, M_RUN | M_GRA | M_ROUT | M_PCIN);
    add_fetch("st", I_ST);
    add("st.T3",  I_ST, M_RUN | M_GRB | M_BAOUT | M_YIN);
    add("st.T4",  I_ST, M_RUN | M_COUT | M_ZLOWIN, 4'd2);
    add("st.T5",  I_ST, M_RUN | M_ZLOWOUT | M_MARIN);
    add("st.T6",  I_ST, M_RUN | M_GRA | M_ROUT | M_MDRIN, 4'd0, 2'd0);
    add("st.T7w", I_ST, M_RUN | M_WRITE, 4'd0, 2'd0, 1'b0, 1'b0);
    add("st.T7",  I_ST, M_RUN | M_WRITE);
    // stop raised mid-fetch but dropped before the boundary has no effect.
    add("nop.T0", I_NOP, T0V, 4'd0, 2'd0, 1'b0, 1'b1, 1'b1);
    add("nop.T1", I_NOP, T1V, 4'd0, 2'd1, 1'b0, 1'b1, 1'b1);
    add("nop.T2", I_NOP, T2V);
    add("rst4.T0", I_ADD, T0V);
    add("rst4.T1", I_ADD, T1V, 4'd0, 2'd1);
    add("rst4.T2", I_ADD, T2V);
    add("rst4.T3", I_ADD, M_RUN | M_GRB | M_ROUT | M_YIN);
    add("rst4.low",  I_ADD, 30'd0, 4'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    add("rst4.low2", I_ADD, 30'd0, 4'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    add("rst4.RST",  I_ADD, 30'd0);
    add("rst4.next", I_LD, T0V);

    foreach (tbl[i])
      step(tbl[i].name, tbl[i].rst, tbl[i].ir, tbl[i].br, tbl[i].rdy, tbl[i].stp,
           tbl[i].bits, tbl[i].ctl, tbl[i].mdr);

    // ld whose memory answers on the last allowed cycle: no fault.
    step("ldok.T1", 1, I_LD, 0, 1, 0, T1V, 4'd0, 2'd1);
    step("ldok.T2", 1, I_LD, 0, 1, 0, T2V, 4'd0, 2'd0);
    step("ldok.T3", 1, I_LD, 0, 1, 0, M_RUN | M_GRB | M_BAOUT | M_YIN, 4'd0, 2'd0);
    step("ldok.T4", 1, I_LD, 0, 1, 0, M_RUN | M_COUT | M_ZLOWIN, 4'd2, 2'd0);
    step("ldok.T5", 1, I_LD, 0, 1, 0, M_RUN | M_ZLOWOUT | M_MARIN, 4'd0, 2'd0);
    for (int i = 0; i < 14; i++)
      step("ldok.T6w", 1, I_LD, 0, 0, 0, M_RUN | M_READ | M_MDRIN, 4'd0, 2'd1);
    step("ldok.T6r", 1, I_LD, 0, 1, 0, M_RUN | M_READ | M_MDRIN, 4'd0, 2'd1);
    step("ldok.T7",  1, I_LD, 0, 1, 0, M_RUN | M_MDROUT | M_GRA | M_RIN, 4'd0, 2'd0);

    // ld whose memory never answers: fault after 15 waiting cycles.
    step("ldto.T0", 1, I_LD, 0, 1, 0, T0V, 4'd0, 2'd0);
    step("ldto.T1", 1, I_LD, 0, 1, 0, T1V, 4'd0, 2'd1);
    step("ldto.T2", 1, I_LD, 0, 1, 0, T2V, 4'd0, 2'd0);
    step("ldto.T3", 1, I_LD, 0, 1, 0, M_RUN | M_GRB | M_BAOUT | M_YIN, 4'd0, 2'd0);
    step("ldto.T4", 1, I_LD, 0, 1, 0, M_RUN | M_COUT | M_ZLOWIN, 4'd2, 2'd0);
    step("ldto.T5", 1, I_LD, 0, 1, 0, M_RUN | M_ZLOWOUT | M_MARIN, 4'd0, 2'd0);
    for (int i = 0; i < 15; i++)
      step("ldto.T6w", 1, I_LD, 0, 0, 0, M_RUN | M_READ | M_MDRIN, 4'd0, 2'd1);
    step("ldto.HALT",  1, I_LD, 0, 1, 0, M_FAULT, 4'd0, 2'd0);
    step("ldto.HALT2", 1, I_LD, 0, 1, 0, M_FAULT, 4'd0, 2'd0);
    step("ldto.rst",   0, I_ADD, 0, 1, 0, 30'd0, 4'd0, 2'd0);
    step("ldto.RST",   1, I_ADD, 0, 1, 0, 30'd0, 4'd0, 2'd0);

    // stop during add: instruction completes, then HALT until reset.
    step("stop.T0", 1, I_ADD, 0, 1, 0, T0V, 4'd0, 2'd0);
    step("stop.T1", 1, I_ADD, 0, 1, 0, T1V, 4'd0, 2'd1);
    step("stop.T2", 1, I_ADD, 0, 1, 0, T2V, 4'd0, 2'd0);
    step("stop.T3", 1, I_ADD, 0, 1, 1, M_RUN | M_GRB | M_ROUT | M_YIN, 4'd0, 2'd0);
    step("stop.T4", 1, I_ADD, 0, 1, 1, M_RUN | M_GRC | M_ROUT | M_ZLOWIN, 4'd2, 2'd0);
    step("stop.T5", 1, I_ADD, 0, 1, 1, M_RUN | M_ZLOWOUT | M_GRA | M_RIN, 4'd0, 2'd0);
    step("stop.HALT",  1, I_ADD, 0, 1, 0, 30'd0, 4'd0, 2'd0);
    step("stop.HALT2", 1, I_ADD, 0, 1, 0, 30'd0, 4'd0, 2'd0);
    step("stop.rst",   0, I_HLT, 0, 1, 0, 30'd0, 4'd0, 2'd0);
    step("stop.RST",   1, I_HLT, 0, 1, 0, 30'd0, 4'd0, 2'd0);

    // halt opcode goes straight from T2 to HALT.
    step("hlt.T0", 1, I_HLT, 0, 1, 0, T0V, 4'd0, 2'd0);
    step("hlt.T1", 1, I_HLT, 0, 1, 0, T1V, 4'd0, 2'd1);
    step("hlt.T2", 1, I_HLT, 0, 1, 0, T2V, 4'd0, 2'd0);
    step("hlt.HALT",  1, I_NOP, 0, 1, 0, 30'd0, 4'd0, 2'd0);
    step("hlt.HALT2", 1, I_NOP, 0, 1, 0, 30'd0, 4'd0, 2'd0);
    step("hlt.rst",   0, I_NOP, 0, 1, 0, 30'd0, 4'd0, 2'd0);
    step("hlt.RST",   1, I_NOP, 0, 1, 0, 30'd0, 4'd0, 2'd0);
    step("hlt.T0n",   1, I_NOP, 0, 1, 0, T0V, 4'd0, 2'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
